// File: rtl/ysyx_25020047_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, decode bit positions,
// error codes, writeback selects and store byte masks.
package ysyx_25020047_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH_REQ  = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC       = 4'd4,
        S_MEM_REQ    = 4'd5,
        S_MEM_WAIT   = 4'd6,
        S_WB         = 4'd7,
        S_HALT       = 4'd8
    } state_t;

    localparam int IT_ADDI   = 0;
    localparam int IT_JALR   = 1;
    localparam int IT_EBREAK = 2;
    localparam int IT_ADD    = 3;
    localparam int IT_LUI    = 4;
    localparam int IT_LW     = 5;
    localparam int IT_LBU    = 6;
    localparam int IT_SW     = 7;
    localparam int IT_SB     = 8;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_IFU_TO  = 2'b10;
    localparam logic [1:0] ERR_LSU_TO  = 2'b11;

    localparam logic [1:0] RSEL_ALU  = 2'b00;
    localparam logic [1:0] RSEL_WORD = 2'b01;
    localparam logic [1:0] RSEL_BYTE = 2'b10;
    localparam logic [1:0] RSEL_SNPC = 2'b11;

    localparam logic [3:0] WMASK_NONE = 4'b0000;
    localparam logic [3:0] WMASK_WORD = 4'b1111;
    localparam logic [3:0] WMASK_BYTE = 4'b0001;

    function automatic logic is_onehot9(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    function automatic logic is_mem(input logic [8:0] op);
        return op[IT_LW] | op[IT_LBU] | op[IT_SW] | op[IT_SB];
    endfunction

    function automatic logic is_store(input logic [8:0] op);
        return op[IT_SW] | op[IT_SB];
    endfunction

    function automatic logic writes_rd(input logic [8:0] op);
        return op[IT_ADDI] | op[IT_JALR] | op[IT_ADD] | op[IT_LUI] | op[IT_LW] | op[IT_LBU];
    endfunction

    function automatic logic [1:0] rsel_of(input logic [8:0] op);
        if (op[IT_LW])        return RSEL_WORD;
        else if (op[IT_LBU])  return RSEL_BYTE;
        else if (op[IT_JALR]) return RSEL_SNPC;
        else                  return RSEL_ALU;
    endfunction

    function automatic logic [3:0] wmask_of(input logic [8:0] op);
        if (op[IT_SW])       return WMASK_WORD;
        else if (op[IT_SB])  return WMASK_BYTE;
        else                 return WMASK_NONE;
    endfunction

endpackage

// File: rtl/ysyx_25020047_mc_ctrl_if.sv
// IFU/LSU valid-ready handshake bundle between the sequencer (master) and the memories.
interface ysyx_25020047_mc_ctrl_if;
    logic       ifu_req_valid;
    logic       ifu_req_ready;
    logic       ifu_resp_valid;
    logic       inst_en;
    logic       lsu_req_valid;
    logic       lsu_req_ready;
    logic       lsu_req_wen;
    logic [3:0] lsu_req_wmask;
    logic       lsu_resp_valid;

    modport master (
        output ifu_req_valid, inst_en, lsu_req_valid, lsu_req_wen, lsu_req_wmask,
        input  ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid
    );

    modport slave (
        input  ifu_req_valid, inst_en, lsu_req_valid, lsu_req_wen, lsu_req_wmask,
        output ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid
    );
endinterface

// File: rtl/ysyx_25020047_wait_timer.sv
// Cycle counter for a request+wait state pair; expire flags the last allowed cycle.
module ysyx_25020047_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + W'(1);
    end

    assign expire = (cnt == LAST);
endmodule

// File: rtl/ysyx_25020047_mc_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with handshake
// timeouts, halt reporting and cycle/retired-instruction counters.
//   state      | meaning
//   IDLE       | one cycle after reset release
//   FETCH_REQ  | ifu request held until accepted
//   FETCH_WAIT | waiting for the instruction word
//   DECODE     | latch inst_type, reject illegal/ebreak
//   EXEC       | one ALU cycle, route memory ops to MEM_REQ
//   MEM_REQ    | lsu request held until accepted
//   MEM_WAIT   | waiting for load data / store ack
//   WB         | register and PC update, retire
//   HALT       | sticky until reset
module ysyx_25020047_mc_ctrl
    import ysyx_25020047_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8:0]            inst_type,
    ysyx_25020047_mc_ctrl_if.master bus,
    output logic [1:0]            rdata_sel,
    output logic                  reg_wen,
    output logic                  pc_wen,
    output logic                  halt,
    output logic [1:0]            err,
    output logic [3:0]            state_o,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      instret
);
    state_t     state, next_state;
    logic [8:0] op_q;
    logic [1:0] err_next;
    logic       expire, timer_clr, timer_en;

    ysyx_25020047_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // The exit handshake is tested before expire so it wins in the same cycle.
    always_comb begin
        next_state = state;
        err_next   = err;
        case (state)
            S_IDLE:       next_state = S_FETCH_REQ;
            S_FETCH_REQ: begin
                if (bus.ifu_req_ready) next_state = S_FETCH_WAIT;
                else if (expire) begin
                    next_state = S_HALT;
                    err_next   = ERR_IFU_TO;
                end
            end
            S_FETCH_WAIT: begin
                if (bus.ifu_resp_valid) next_state = S_DECODE;
                else if (expire) begin
                    next_state = S_HALT;
                    err_next   = ERR_IFU_TO;
                end
            end
            S_DECODE: begin
                if (!is_onehot9(inst_type)) begin
                    next_state = S_HALT;
                    err_next   = ERR_ILLEGAL;
                end else if (inst_type[IT_EBREAK]) begin
                    next_state = S_HALT;
                    err_next   = ERR_NONE;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC:       next_state = is_mem(op_q) ? S_MEM_REQ : S_WB;
            S_MEM_REQ: begin
                if (bus.lsu_req_ready) next_state = S_MEM_WAIT;
                else if (expire) begin
                    next_state = S_HALT;
                    err_next   = ERR_LSU_TO;
                end
            end
            S_MEM_WAIT: begin
                if (bus.lsu_resp_valid) next_state = S_WB;
                else if (expire) begin
                    next_state = S_HALT;
                    err_next   = ERR_LSU_TO;
                end
            end
            S_WB:         next_state = S_FETCH_REQ;
            S_HALT:       next_state = S_HALT;
            default:      next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ifu_req_valid = 1'b0;
        bus.inst_en       = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_wmask = WMASK_NONE;
        rdata_sel         = RSEL_ALU;
        reg_wen           = 1'b0;
        pc_wen            = 1'b0;
        halt              = 1'b0;
        case (state)
            S_FETCH_REQ:  bus.ifu_req_valid = 1'b1;
            S_FETCH_WAIT: bus.inst_en = bus.ifu_resp_valid;
            S_MEM_REQ: begin
                bus.lsu_req_valid = 1'b1;
                bus.lsu_req_wen   = is_store(op_q);
                bus.lsu_req_wmask = wmask_of(op_q);
            end
            S_WB: begin
                pc_wen    = 1'b1;
                reg_wen   = writes_rd(op_q);
                rdata_sel = rsel_of(op_q);
            end
            S_HALT:       halt = 1'b1;
            default:      ;
        endcase
    end

    // Timer restarts only on entry to a request state, so it spans the req+wait pair.
    assign timer_clr = ((next_state == S_FETCH_REQ) && (state != S_FETCH_REQ)) ||
                       ((next_state == S_MEM_REQ)   && (state != S_MEM_REQ));
    assign timer_en  = (state == S_FETCH_REQ) || (state == S_FETCH_WAIT) ||
                       (state == S_MEM_REQ)   || (state == S_MEM_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            err       <= ERR_NONE;
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (state == S_DECODE) op_q <= inst_type;
            if (state != S_HALT) begin
                err       <= err_next;
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (state == S_WB) instret <= instret + CNT_W'(1);
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_ysyx_25020047_mc_ctrl.sv
// Directed plus randomized-delay bench for the multi-cycle sequencer, checked
// against a per-instruction timeline model built from the decode rules.
module tb_ysyx_25020047_mc_ctrl;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  inst_type = '0;
    logic [1:0]  rdata_sel;
    logic        reg_wen, pc_wen, halt;
    logic [1:0]  err;
    logic [3:0]  state_o;
    logic [31:0] cycle_cnt, instret;

    ysyx_25020047_mc_ctrl_if bus();

    ysyx_25020047_mc_ctrl #(.TIMEOUT_CYC(T), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_type (inst_type),
        .bus       (bus),
        .rdata_sel (rdata_sel),
        .reg_wen   (reg_wen),
        .pc_wen    (pc_wen),
        .halt      (halt),
        .err       (err),
        .state_o   (state_o),
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ret = 0;
    bit halted_m = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] st, input logic ifv, input logic ien,
                           input logic lv, input logic lwen, input logic [3:0] wm, input logic [1:0] rs,
                           input logic rw, input logic pw, input logic h);
        chk(tag, {state_o, bus.ifu_req_valid, bus.inst_en, bus.lsu_req_valid, bus.lsu_req_wen,
                  bus.lsu_req_wmask, rdata_sel, reg_wen, pc_wen, halt},
                 {st, ifv, ien, lv, lwen, wm, rs, rw, pw, h});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!halted_m) cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ifu_req_ready = 0; bus.ifu_resp_valid = 0;
        bus.lsu_req_ready = 0; bus.lsu_resp_valid = 0;
        @(posedge clk);
        #1;
        chk_out("reset_outputs", 4'd0, 0, 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        chk("reset_counters", {cycle_cnt, instret}, 64'd0);
        chk("reset_err", err, 2'd0);
        rst = 1'b0;
        cyc = 0; ret = 0; halted_m = 0;
        inst_type = 9'($urandom);
        @(negedge clk);
        chk_out("idle", 4'd0, 0, 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        tick();
    endtask

    task automatic expect_halt(input logic [1:0] e, input int n);
        halted_m = 1;
        for (int i = 0; i < n; i++) begin
            bus.ifu_req_ready = 1'($urandom); bus.ifu_resp_valid = 1'($urandom);
            bus.lsu_req_ready = 1'($urandom); bus.lsu_resp_valid = 1'($urandom);
            inst_type = 9'($urandom);
            @(negedge clk);
            chk_out("halt_outputs", 4'd8, 0, 0, 0, 0, 4'h0, 2'd0, 0, 0, 1);
            chk("halt_err", err, e);
            chk("halt_frozen", {cycle_cnt, instret}, {32'(cyc), 32'(ret)});
            tick();
        end
        bus.ifu_req_ready = 0; bus.ifu_resp_valid = 0;
        bus.lsu_req_ready = 0; bus.lsu_resp_valid = 0;
    endtask

    // One instruction; d* are cycles of delay before each handshake input rises.
    task automatic run_instr(input logic [8:0] it, input int dr, input int drs,
                             input int dl, input int dlr, input int nh);
        bit legal, ebrk, mem, store, to;
        logic [3:0] wm;
        logic [1:0] rs;
        int k;
        legal = ($countones(it) == 1);
        ebrk  = (it == 9'h004);
        mem   = |(it & 9'h1e0);
        store = |(it & 9'h180);
        wm    = it[7] ? 4'hf : (it[8] ? 4'h1 : 4'h0);
        rs    = it[5] ? 2'd1 : (it[6] ? 2'd2 : (it[1] ? 2'd3 : 2'd0));
        k = 0; to = 0;
        for (int c = 0; c <= dr && !to; c++) begin
            bus.ifu_req_ready  = (c == dr);
            bus.ifu_resp_valid = 1'($urandom);
            inst_type = 9'($urandom);
            @(negedge clk);
            chk_out("fetch_req", 4'd1, 1, 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
            if (c == 0) chk("instret", instret, 32'(ret));
            if (c != dr && k == T - 1) to = 1;
            tick();
            k++;
        end
        bus.ifu_req_ready = 0;
        for (int c = 0; c <= drs && !to; c++) begin
            bus.ifu_resp_valid = (c == drs);
            @(negedge clk);
            chk_out("fetch_wait", 4'd2, 0, (c == drs), 0, 0, 4'h0, 2'd0, 0, 0, 0);
            if (c != drs && k == T - 1) to = 1;
            tick();
            k++;
        end
        bus.ifu_resp_valid = 0;
        if (to) begin expect_halt(2'b10, nh); return; end
        inst_type = it;
        @(negedge clk);
        chk_out("decode", 4'd3, 0, 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        tick();
        inst_type = 9'($urandom);
        if (!legal || ebrk) begin expect_halt(legal ? 2'b00 : 2'b01, nh); return; end
        @(negedge clk);
        chk_out("exec", 4'd4, 0, 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        tick();
        if (mem) begin
            k = 0;
            for (int c = 0; c <= dl && !to; c++) begin
                bus.lsu_req_ready = (c == dl);
                @(negedge clk);
                chk_out("mem_req", 4'd5, 0, 0, 1, store, wm, 2'd0, 0, 0, 0);
                if (c != dl && k == T - 1) to = 1;
                tick();
                k++;
            end
            bus.lsu_req_ready = 0;
            for (int c = 0; c <= dlr && !to; c++) begin
                bus.lsu_resp_valid = (c == dlr);
                @(negedge clk);
                chk_out("mem_wait", 4'd6, 0, 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
                if (c != dlr && k == T - 1) to = 1;
                tick();
                k++;
            end
            bus.lsu_resp_valid = 0;
            if (to) begin expect_halt(2'b11, nh); return; end
        end
        @(negedge clk);
        chk_out("writeback", 4'd7, 0, 0, 0, 0, 4'h0, rs, !store, 1, 0);
        chk("cycle_cnt", cycle_cnt, 32'(cyc));
        tick();
        ret++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int idx;
        logic [8:0] it;
        bus.ifu_req_ready = 0; bus.ifu_resp_valid = 0;
        bus.lsu_req_ready = 0; bus.lsu_resp_valid = 0;

        do_reset();
        run_instr(9'h001, 0, 0, 0, 0, 0);     // addi, zero wait
        run_instr(9'h020, 0, 0, 3, 2, 0);     // lw, slow LSU
        run_instr(9'h100, 0, 0, 0, 0, 0);     // sb
        run_instr(9'h002, 1, 2, 0, 0, 0);     // jalr
        for (int n = 0; n < 25; n++) begin
            idx = $urandom_range(0, 7);
            if (idx >= 2) idx++;
            it = 9'b1 << idx;
            run_instr(it, $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 4), 0);
        end
        run_instr(9'h004, 0, 0, 0, 0, 20);    // ebreak

        do_reset();
        run_instr(9'h000, 0, 0, 0, 0, 3);
        do_reset();
        run_instr(9'h003, 0, 0, 0, 0, 3);
        do_reset();
        run_instr(9'h001, 20, 0, 0, 0, 3);    // fetch never accepted
        do_reset();
        run_instr(9'h020, 0, 1, 2, 40, 3);    // load response never arrives

        // Reset asserted in the middle of MEM_WAIT.
        do_reset();
        bus.ifu_req_ready = 1; tick();
        bus.ifu_req_ready = 0; bus.ifu_resp_valid = 1; tick();
        bus.ifu_resp_valid = 0; inst_type = 9'h020; tick();
        tick();
        bus.lsu_req_ready = 1; tick();
        bus.lsu_req_ready = 0;
        @(negedge clk);
        chk("mw_state", state_o, 4'd6);
        #2 rst = 1'b1;
        #1;
        chk_out("async_reset", 4'd0, 0, 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        chk("async_reset_cnt", {cycle_cnt, instret}, 64'd0);
        @(posedge clk);
        #1;
        bus.lsu_resp_valid = 1;
        rst = 1'b0;
        cyc = 0; ret = 0; halted_m = 0;
        @(negedge clk);
        chk_out("post_reset_idle", 4'd0, 0, 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        tick();
        @(negedge clk);
        chk_out("late_resp_ignored", 4'd1, 1, 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        chk("post_reset_cycle", cycle_cnt, 32'(cyc));
        tick();
        @(negedge clk);
        chk("late_resp_hold", state_o, 4'd1);
        bus.lsu_resp_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ysyx_25020047_mc_ctrl.md
Name: ysyx_25020047_mc_ctrl

Overview:
Multi-cycle sequencer for the single-issue core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the IFU/LSU valid-ready handshakes and the register-file and PC write enables. It consumes the one-hot inst_type from the decoder, and halts on ebreak, illegal instructions or memory timeouts.

Parameters:
TIMEOUT_CYC, 16, maximum cycles spent in a request+wait state pair before a timeout halt (must be ≥2).
CNT_W, 32, width of the cycle and retired-instruction counters.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
inst_type  in  9  one-hot decode: b0 addi, b1 jalr, b2 ebreak, b3 add, b4 lui, b5 lw, b6 lbu, b7 sw, b8 sb
ifu_req_valid  out  1  instruction fetch request
ifu_req_ready  in  1  IFU accepts request
ifu_resp_valid  in  1  instruction word available
inst_en  out  1  latch fetched word into IR
lsu_req_valid  out  1  data memory request
lsu_req_ready  in  1  LSU accepts request
lsu_req_wen  out  1  1 = store
lsu_req_wmask  out  4  byte mask: sw 4'b1111, sb 4'b0001; 0 otherwise
lsu_resp_valid  in  1  load data / store ack
rdata_sel  out  2  writeback source: 00 ALU, 01 mem word, 10 mem byte zero-ext, 11 snpc
reg_wen  out  1  GPR write enable
pc_wen  out  1  PC update (dnpc) enable
halt  out  1  core halted
err  out  2  00 none/ebreak, 01 illegal inst, 10 fetch timeout, 11 LSU timeout
state_o  out  4  current state (debug)
cycle_cnt  out  CNT_W  cycles since reset while not halted
instret  out  CNT_W  retired instructions

Behaviour:
- Reset (async, immediate): state=IDLE; op_q, wait_cnt, cycle_cnt, instret, err = 0. All strobes are Moore outputs decoded from the state register, so every output is 0 during reset.
- States: IDLE(0), FETCH_REQ(1), FETCH_WAIT(2), DECODE(3), EXEC(4), MEM_REQ(5), MEM_WAIT(6), WB(7), HALT(8).
- IDLE: go to FETCH_REQ on the first clock after rst deasserts. All inputs are ignored.
- FETCH_REQ: ifu_req_valid=1. Go to FETCH_WAIT when ifu_req_ready=1. A resp arriving in this state is ignored.
- FETCH_WAIT: when ifu_resp_valid=1, assert inst_en=1 (combinational, that cycle only) and go to DECODE.
- DECODE: capture inst_type into op_q.
  - Zero or non-one-hot: go to HALT with err=01.
  - ebreak: go to HALT with err=00.
  - Otherwise: go to EXEC.
- EXEC: one cycle. lw/lbu/sw/sb go to MEM_REQ; all others go to WB.
- MEM_REQ: lsu_req_valid=1. lsu_req_wen and lsu_req_wmask come from op_q. Go to MEM_WAIT on lsu_req_ready. The request stays asserted and stable until accepted.
- MEM_WAIT: go to WB on lsu_resp_valid. Stores also wait for the ack.
- WB (one cycle):
  - pc_wen=1 always.
  - reg_wen=1 for addi, jalr, add, lui, lw, lbu; 0 for sw, sb.
  - rdata_sel: lw 01, lbu 10, jalr 11, else 00. rdata_sel=00 outside WB.
  - instret+1, then go to FETCH_REQ.
- HALT: halt=1. State is sticky until rst. No requests are issued; cycle_cnt and instret are frozen.
- Timeout:
  - wait_cnt clears on entry to FETCH_REQ and to MEM_REQ.
  - In REQ/WAIT states, if the exit event is absent and wait_cnt==TIMEOUT_CYC-1, go to HALT with err=10 (fetch) or 11 (LSU). Otherwise wait_cnt+1.
  - The exit handshake wins over timeout in the same cycle.
- Counters wrap modulo 2^CNT_W. cycle_cnt increments in every non-HALT state, including IDLE.
- Latency, zero-wait memory: ALU instruction 5 cycles (FR, FW, DEC, EXEC, WB); memory instruction 7 cycles.

Decomposition:
- Package ysyx_25020047_ctrl_pkg holds:
  - state encoding
  - inst_type bit indices
  - err codes
  - rdata_sel codes
  - wmask constants
- Sub-module ysyx_25020047_wait_timer holds the clear/enable/expire counter parameterised by TIMEOUT_CYC.

Test Plan:
- Release rst, addi, ifu ready/resp immediate → states 0,1,2,3,4,7,1. reg_wen=pc_wen=1 only in cycle 6 after release, rdata_sel=00, instret=1.
- lw with lsu_req_ready after 3 cycles, resp 2 cycles later → lsu_req_valid high 4 cycles, wen=0, wmask=0. In WB: rdata_sel=01, reg_wen=1.
- sb, immediate LSU → wen=1, wmask=4'b0001 in MEM_REQ. In WB: reg_wen=0, pc_wen=1. jalr → rdata_sel=11, reg_wen=1.
- ebreak → HALT, halt=1, err=00, ifu_req_valid stays 0, cycle_cnt frozen for 20 cycles.
- inst_type=9'b0 → err=01. inst_type=9'b000000011 → err=01.
- TIMEOUT_CYC=16, ifu_req_ready stuck 0 → ifu_req_valid high exactly 16 cycles, then halt, err=10. Next run: assert rst mid-MEM_WAIT → all outputs 0 immediately, counters 0, a late lsu_resp_valid is ignored.
